// File: rtl/mem_if_pkg.sv
// Memory command protocol definitions shared by the
// issuer and the memory-side port.
package mem_if_pkg;

  typedef enum logic [1:0] {
    RD_KEY  = 2'd0,
    RD_TEXT = 2'd1,
    WR_RES  = 2'd2,
    HASH_OP = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    MEM  = 2'd0,
    SHA  = 2'd1,
    AES  = 2'd2,
    CTRL = 2'd3
  } mod_id_e;

  typedef struct packed {
    logic       enc_dec;
    logic       rsvd;
    logic [1:0] dest;
    logic [1:0] source;
    logic [1:0] opcode;
  } hdr_t;

  function automatic logic [7:0] beats_for(
    input logic [1:0] op,
    input logic [1:0] src
  );
    logic [7:0] n;
    n = 8'd0;
    unique case (op)
      RD_KEY:  n = 8'd32;
      HASH_OP: n = 8'd0;
      default: begin
        unique case (src)
          SHA:     n = 8'd32;
          AES:     n = 8'd16;
          default: n = 8'd0;
        endcase
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_cmd_issuer.sv
// Issuer side of the memory command protocol: header, data, ack.
// Optional counters: define CMD_ISSUER_STATS_EN.
module mem_cmd_issuer
  import mem_if_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_enc_dec,
  input  logic [1:0]  req_dest,
  input  logic [1:0]  req_source,
  input  logic [1:0]  req_opcode,
  input  logic [23:0] req_addr,
  input  logic [7:0]  wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [7:0]  bus_data_out,
  output logic        bus_valid_out,
  input  logic        bus_ready_in,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_valid_in,
  output logic        bus_ready_out,
  output logic        drive_bus,
  input  logic        ack_valid,
  input  logic [1:0]  ack_id,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [15:0] stat_cmds,
  output logic [7:0]  stat_timeouts
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WDATA,
    S_RDATA, S_WAIT_ACK, S_DONE
  } state_e;

  localparam logic [15:0] TMO_LAST =
    16'(ACK_TIMEOUT - 1);

  state_e      state;
  state_e      hdr_next;
  opcode_e     op_q;
  logic [23:0] addr_q;
  logic [7:0]  n_q;
  logic [7:0]  cnt;
  logic [1:0]  beat;
  logic [15:0] timer;
  logic        ack_seen;
  logic        done_q;
  logic        err_q;
  logic [7:0]  hdr_byte;
  logic        hdr_valid;
  logic [7:0]  next_byte;
  logic        ack_hit;
  logic        ack_armed;
  logic        in_wdata;
  logic        in_rdata;
  hdr_t        hdr_in;

  assign in_wdata  = (state == S_WDATA);
  assign in_rdata  = (state == S_RDATA);
  assign ack_hit   = ack_valid && (ack_id == CTRL);
  assign ack_armed = in_wdata || in_rdata ||
                     (state == S_WAIT_ACK);

  assign hdr_in = '{
    enc_dec: req_enc_dec,
    rsvd:    1'b0,
    dest:    req_dest,
    source:  req_source,
    opcode:  req_opcode
  };

  // address byte following the beat now on the bus
  always_comb begin
    next_byte = 8'h00;
    unique case (beat)
      2'd0:    next_byte = addr_q[7:0];
      2'd1:    next_byte = addr_q[15:8];
      2'd2:    next_byte = addr_q[23:16];
      default: next_byte = 8'h00;
    endcase
  end

  // phase entered once the last header beat is taken
  always_comb begin
    hdr_next = S_WAIT_ACK;
    if (n_q != 8'd0) begin
      if (op_q == WR_RES)
        hdr_next = S_WDATA;
      else if (op_q == RD_KEY || op_q == RD_TEXT)
        hdr_next = S_RDATA;
    end
  end

  // command sequencer with registered header beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= RD_KEY;
      addr_q    <= '0;
      n_q       <= '0;
      cnt       <= '0;
      beat      <= '0;
      timer     <= '0;
      ack_seen  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hdr_byte  <= '0;
      hdr_valid <= 1'b0;
    end else begin
      if (ack_armed && ack_hit)
        ack_seen <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= opcode_e'(req_opcode);
            addr_q    <= req_addr;
            n_q       <= beats_for(req_opcode,
                                   req_source);
            beat      <= 2'd0;
            hdr_byte  <= hdr_in;
            hdr_valid <= 1'b1;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (hdr_valid && bus_ready_in) begin
            if (beat == 2'd3) begin
              hdr_valid <= 1'b0;
              hdr_byte  <= '0;
              beat      <= 2'd0;
              state     <= hdr_next;
            end else begin
              beat     <= beat + 2'd1;
              hdr_byte <= next_byte;
            end
          end
        end
        S_WDATA: begin
          if (wdata_valid && bus_ready_in) begin
            if (cnt == n_q - 8'd1) begin
              cnt   <= '0;
              state <= S_WAIT_ACK;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        S_RDATA: begin
          if (bus_valid_in && rdata_ready) begin
            if (cnt == n_q - 8'd1) begin
              cnt   <= '0;
              state <= S_WAIT_ACK;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        S_WAIT_ACK: begin
          if (ack_seen || ack_hit) begin
            done_q <= 1'b1;
            err_q  <= 1'b0;
            state  <= S_DONE;
          end else if (timer == TMO_LAST) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= S_DONE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_DONE: begin
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          ack_seen <= 1'b0;
          timer    <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign drive_bus     = (state == S_HDR) || in_wdata;
  assign bus_data_out  = in_wdata ? wdata : hdr_byte;
  assign bus_valid_out = in_wdata ? wdata_valid
                                  : hdr_valid;
  assign wdata_ready   = in_wdata && bus_ready_in;
  assign rdata         = in_rdata ? bus_data_in : 8'h00;
  assign rdata_valid   = in_rdata && bus_valid_in;
  assign bus_ready_out = in_rdata && rdata_ready;
  assign done          = done_q;
  assign err_timeout   = err_q;

`ifdef CMD_ISSUER_STATS_EN
  logic [15:0] cmds_q;
  logic [7:0]  tmo_q;

  // saturating completion and timeout counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmds_q <= '0;
      tmo_q  <= '0;
    end else if (done_q) begin
      if (cmds_q != 16'hFFFF)
        cmds_q <= cmds_q + 16'd1;
      if (err_q && tmo_q != 8'hFF)
        tmo_q <= tmo_q + 8'd1;
    end
  end

  assign stat_cmds     = cmds_q;
  assign stat_timeouts = tmo_q;
`else
  assign stat_cmds     = 16'd0;
  assign stat_timeouts = 8'd0;
`endif

endmodule
